usb_rx_decoder: RTL and testbench

Bit-level receive decoder placed directly downstream of the clock/data recovery stage. It consumes the retimed line state `q` and the data strobe from that stage. It performs SYNC detection, NRZI decoding, bit unstuffing, LSB-first byte assembly and EOP/error detection. It presents whole bytes to the packet layer with a single-cycle valid pulse.

---
 rtl/types.sv | 9 +
 rtl/usb_rx_unstuff.sv | 39 +++
 rtl/usb_rx_decoder.sv | 151 +++++++++++++++
 tb/tb_usb_rx_decoder.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/types.sv
// types: line-state encoding and receive FSM states shared by the USB RX decoder files.
package types;
    typedef logic [1:0] d_port_t;
    localparam d_port_t SE0 = 2'b00;
    localparam d_port_t K   = 2'b01;
    localparam d_port_t J   = 2'b10;
    localparam d_port_t SE1 = 2'b11;
    typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP, ERROR} rx_state_t;
endpackage

// File: rtl/usb_rx_unstuff.sv
// usb_rx_unstuff: NRZI decode of J/K strobes plus removal of the stuffed 0 after six 1s.
module usb_rx_unstuff
    import types::*;
(
    input  logic    clk,
    input  logic    reset_n,
    input  logic    strobe_i,
    input  d_port_t d_i,
    input  logic    data_en_i,
    output logic    bit_o,
    output logic    jk_o,
    output logic    bit_valid_o,
    output logic    stuff_err_o
);
    d_port_t    prev_q, prev_d;
    logic [2:0] ones_q, ones_d;
    logic       jk, stuff;
    assign jk          = d_i == J || d_i == K;
    assign stuff       = ones_q == 3'd6;
    assign bit_o       = d_i == prev_q;
    assign jk_o        = strobe_i && jk;
    assign bit_valid_o = jk_o && data_en_i && !stuff;
    assign stuff_err_o = jk_o && data_en_i && stuff && bit_o;
    // Outside DATA the ones count is held at zero so each packet starts clean.
    always_comb begin
        prev_d = jk_o ? d_i : prev_q;
        ones_d = !strobe_i ? ones_q : !data_en_i ? 3'd0 : !jk ? ones_q :
                 (stuff || !bit_o) ? 3'd0 : ones_q + 3'd1;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q <= J;
            ones_q <= 3'd0;
        end else begin
            prev_q <= prev_d;
            ones_q <= ones_d;
        end
    end
endmodule

// File: rtl/usb_rx_decoder.sv
// usb_rx_decoder: SYNC detect, byte assembly and EOP/error framing on top of usb_rx_unstuff.
// Define USB_RX_BUS_RESET_EN to add SE0-run bus reset detection.
module usb_rx_decoder
    import types::*;
#(
    parameter int IDLE_BITS  = 8,
    parameter int RESET_BITS = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  d_port_t    d,
    input  logic       strobe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_active,
    output logic       rx_eop,
    output logic       rx_error,
    output logic       bus_reset
);
    localparam int LIM = IDLE_BITS > RESET_BITS ? IDLE_BITS : RESET_BITS;
    localparam int CW  = $clog2(LIM + 8);
    rx_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bits_q, bits_d;
    logic [7:0]    shift_q, shift_d, data_q, data_d;
    logic          se0_last_q, se0_last_d;
    logic          valid_q, valid_d, eop_q, eop_d, err_q, err_d, active_q, active_d;
    logic          nrz, jk, bit_valid, stuff_err, brst;
    usb_rx_unstuff u_unstuff (
        .clk         (clk),
        .reset_n     (reset_n),
        .strobe_i    (strobe),
        .d_i         (d),
        .data_en_i   (state_q == DATA),
        .bit_o       (nrz),
        .jk_o        (jk),
        .bit_valid_o (bit_valid),
        .stuff_err_o (stuff_err)
    );
`ifdef USB_RX_BUS_RESET_EN
    logic [CW-1:0] se0_q, se0_d;
    logic          bus_reset_q;
    assign se0_d = !strobe ? se0_q : d != SE0 ? '0 :
                   se0_q == CW'(RESET_BITS) ? se0_q : se0_q + CW'(1);
    assign brst      = strobe && se0_d == CW'(RESET_BITS);
    assign bus_reset = bus_reset_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            se0_q       <= '0;
            bus_reset_q <= 1'b0;
        end else begin
            se0_q       <= se0_d;
            bus_reset_q <= se0_d == CW'(RESET_BITS);
        end
    end
`else
    assign brst      = 1'b0;
    assign bus_reset = 1'b0;
`endif
    // cnt_q is shared: SYNC zeros, EOP SE0 strobes, ERROR consecutive J strobes.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bits_d     = bits_q;
        shift_d    = shift_q;
        data_d     = data_q;
        se0_last_d = se0_last_q;
        valid_d    = 1'b0;
        eop_d      = 1'b0;
        err_d      = 1'b0;
        if (strobe) begin
            se0_last_d = d == SE0;
            case (state_q)
                IDLE: if (d == K) begin
                    state_d = SYNC;
                    cnt_d   = '0;
                end
                SYNC: if (!jk) state_d = d == SE0 ? IDLE : ERROR;
                else if (!nrz) cnt_d = cnt_q == CW'(7) ? cnt_q : cnt_q + CW'(1);
                else if (cnt_q >= CW'(5)) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    bits_d  = 3'd0;
                end else state_d = IDLE;
                DATA: if (stuff_err || d == SE1) state_d = ERROR;
                else if (d == SE0) begin
                    state_d = EOP;
                    cnt_d   = CW'(1);
                end else if (bit_valid) begin
                    shift_d = {nrz, shift_q[7:1]};
                    bits_d  = bits_q + 3'd1;
                    data_d  = bits_q == 3'd7 ? shift_d : data_q;
                    valid_d = bits_q == 3'd7;
                end
                EOP: if (d == J) begin
                    state_d = IDLE;
                    eop_d   = bits_q == 3'd0;
                    err_d   = bits_q != 3'd0;
                end else if (d == SE0 && cnt_q == CW'(1)) cnt_d = CW'(2);
`ifdef USB_RX_BUS_RESET_EN
                else if (d == SE0) state_d = EOP;
`endif
                else state_d = ERROR;
                ERROR: if (d != J) cnt_d = '0;
                else if (se0_last_q || cnt_q == CW'(IDLE_BITS - 1)) state_d = IDLE;
                else cnt_d = cnt_q + CW'(1);
                default: state_d = IDLE;
            endcase
            if (state_d == ERROR && state_q != ERROR) begin
                err_d = 1'b1;
                cnt_d = '0;
            end
            if (brst) begin
                state_d = IDLE;
                err_d   = 1'b0;
                eop_d   = 1'b0;
            end
        end
        active_d = state_d == DATA || state_d == EOP;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bits_q     <= 3'd0;
            shift_q    <= 8'd0;
            data_q     <= 8'd0;
            se0_last_q <= 1'b0;
            valid_q    <= 1'b0;
            eop_q      <= 1'b0;
            err_q      <= 1'b0;
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bits_q     <= bits_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            se0_last_q <= se0_last_d;
            valid_q    <= valid_d;
            eop_q      <= eop_d;
            err_q      <= err_d;
            active_q   <= active_d;
        end
    end
    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign rx_eop    = eop_q;
    assign rx_error  = err_q;
    assign rx_active = active_q;
endmodule

// File: tb/tb_usb_rx_decoder.sv
// tb_usb_rx_decoder: table vectors, hand-timed corner sequences and random packets against a line-level encoder model.
module tb_usb_rx_decoder;
    import types::*;
    logic       clk = 1'b0, reset_n = 1'b0, strobe = 1'b0;
    d_port_t    d = J;
    logic [7:0] rx_data;
    logic       rx_valid, rx_active, rx_eop, rx_error, bus_reset;
    usb_rx_decoder dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .d         (d),
        .strobe    (strobe),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_active (rx_active),
        .rx_eop    (rx_eop),
        .rx_error  (rx_error),
        .bus_reset (bus_reset)
    );
    always #5 clk = ~clk;
    int n_cmp = 0, n_bad = 0;
    logic [7:0] got[$];
    int eops, errs, bad_valid;
    always @(negedge clk) begin
        if (rx_valid) begin
            got.push_back(rx_data);
            if (!rx_active) bad_valid++;
        end
        if (rx_eop) eops++;
        if (rx_error) errs++;
    end
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask
    // Line-level encoder: bits -> stuffed -> NRZI symbols, starting from idle J.
    d_port_t cur = J;
    int      ones = 0;
    d_port_t sq[$];
    function automatic void raw(input logic b);
        if (!b) cur = (cur == J) ? K : J;
        sq.push_back(cur);
    endfunction
    function automatic void dbit(input logic b);
        raw(b);
        ones = b ? ones + 1 : 0;
        if (ones == 6) begin
            raw(1'b0);
            ones = 0;
        end
    endfunction
    function automatic void sync_n(input int z);
        cur  = J;
        ones = 0;
        for (int i = 0; i < z; i++) raw(1'b0);
        raw(1'b1);
    endfunction
    function automatic void put_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) dbit(b[i]);
    endfunction
    function automatic void eop();
        sq.push_back(SE0);
        sq.push_back(SE0);
        sq.push_back(J);
        cur = J;
    endfunction
    task automatic sym(input d_port_t s, input int gap);
        d      = s;
        strobe = 1'b1;
        @(negedge clk);
        strobe = 1'b0;
        repeat (gap) @(negedge clk);
    endtask
    task automatic play(input bit rnd);
        for (int i = 0; i < sq.size(); i++) sym(sq[i], rnd ? int'($urandom_range(0, 2)) : 0);
        sq.delete();
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) sym(J, 0);
    endtask
    task automatic clr();
        got.delete();
        eops      = 0;
        errs      = 0;
        bad_valid = 0;
    endtask
    typedef struct {
        logic [255:0] syms;
        int           n;
        int           nb;
        logic [7:0]   first;
        logic [7:0]   last;
        int           ne;
        int           nerr;
    } vec_t;
    vec_t vt[12];
    int   nv = 0;
    task automatic mk(input int nb, input logic [7:0] f, input logic [7:0] l, input int ne, input int nerr);
        vt[nv].syms = '0;
        for (int i = 0; i < sq.size(); i++) vt[nv].syms[2*i +: 2] = sq[i];
        vt[nv].n     = sq.size();
        vt[nv].nb    = nb;
        vt[nv].first = f;
        vt[nv].last  = l;
        vt[nv].ne    = ne;
        vt[nv].nerr  = nerr;
        nv++;
        sq.delete();
    endtask
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
    initial begin
        logic [7:0] exp_q[$];
        sync_n(7); put_byte(8'h69); eop(); mk(1, 8'h69, 8'h69, 1, 0);
        sync_n(7); put_byte(8'hFF); put_byte(8'h01); eop(); mk(2, 8'hFF, 8'h01, 1, 0);
        sync_n(7); repeat (7) raw(1'b1); mk(0, 8'h00, 8'h00, 0, 1);
        sync_n(7); dbit(1); dbit(0); dbit(1); dbit(1); dbit(0); eop(); mk(0, 8'h00, 8'h00, 0, 1);
        sync_n(3); mk(0, 8'h00, 8'h00, 0, 0);
        sync_n(7); dbit(1); dbit(0); dbit(0); sq.push_back(SE1); mk(0, 8'h00, 8'h00, 0, 1);
        sync_n(7); put_byte(8'hA5); repeat (3) sq.push_back(SE0); sq.push_back(J);
`ifdef USB_RX_BUS_RESET_EN
        mk(1, 8'hA5, 8'hA5, 1, 0);
`else
        mk(1, 8'hA5, 8'hA5, 0, 1);
`endif
        cur = J; raw(1'b0); raw(1'b0); raw(1'b0); sq.push_back(SE1); mk(0, 8'h00, 8'h00, 0, 1);
        sync_n(7); put_byte(8'hF0); put_byte(8'hFF); eop(); mk(2, 8'hF0, 8'hFF, 1, 0);
        sync_n(6); put_byte(8'h3C); eop(); mk(1, 8'h3C, 8'h3C, 1, 0);
        sync_n(5); mk(0, 8'h00, 8'h00, 0, 0);
        sync_n(7); put_byte(8'h00); put_byte(8'h7E); eop(); mk(2, 8'h00, 8'h7E, 1, 0);
        repeat (3) @(negedge clk);
        chk("rst_data", rx_data, 8'h00);
        chk("rst_valid", rx_valid, 0);
        chk("rst_active", rx_active, 0);
        chk("rst_eop", rx_eop, 0);
        chk("rst_error", rx_error, 0);
        chk("rst_bus_reset", bus_reset, 0);
        reset_n = 1'b1;
        @(negedge clk);
        idle(2);
        for (int v = 0; v < nv; v++) begin
            clr();
            for (int i = 0; i < vt[v].n; i++) sym(d_port_t'(vt[v].syms[2*i +: 2]), int'($urandom_range(0, 2)));
            idle(12);
            chk($sformatf("v%0d_nbytes", v), got.size(), vt[v].nb);
            if (vt[v].nb > 0) begin
                chk($sformatf("v%0d_first", v), got.size() > 0 ? 32'(got[0]) : 32'hDEAD, vt[v].first);
                chk($sformatf("v%0d_last", v), got.size() > 0 ? 32'(got[got.size()-1]) : 32'hDEAD, vt[v].last);
            end
            chk($sformatf("v%0d_eops", v), eops, vt[v].ne);
            chk($sformatf("v%0d_errs", v), errs, vt[v].nerr);
            chk($sformatf("v%0d_valid_outside_active", v), bad_valid, 0);
            chk($sformatf("v%0d_active_after", v), rx_active, 0);
        end
        // Pulse timing on the last data strobe and on the EOP J strobe.
        clr();
        sync_n(7); put_byte(8'h69);
        for (int i = 0; i < sq.size(); i++) sym(sq[i], 0);
        sq.delete();
        chk("t_valid_next_cycle", rx_valid, 1);
        chk("t_data", rx_data, 8'h69);
        chk("t_active_data", rx_active, 1);
        @(negedge clk);
        chk("t_valid_one_cycle", rx_valid, 0);
        sym(SE0, 0); sym(SE0, 0);
        chk("t_active_eop", rx_active, 1);
        chk("t_no_early_eop", rx_eop, 0);
        sym(J, 0);
        chk("t_eop_pulse", rx_eop, 1);
        chk("t_active_drop", rx_active, 0);
        @(negedge clk);
        chk("t_eop_one_cycle", rx_eop, 0);
        idle(4);
        // ERROR exit needs IDLE_BITS consecutive J strobes: 7 is not enough, 8 is.
        for (int nj = 7; nj <= 8; nj++) begin
            clr();
            sync_n(7); repeat (7) raw(1'b1);
            play(1);
            sym(J, 0);
            chk($sformatf("e%0d_active_low", nj), rx_active, 0);
            for (int i = 1; i < nj; i++) sym(J, 0);
            sync_n(7); put_byte(8'h11); eop(); play(1);
            idle(12);
            chk($sformatf("e%0d_nbytes", nj), got.size(), nj == 8 ? 1 : 0);
            chk($sformatf("e%0d_eops", nj), eops, nj == 8 ? 1 : 0);
            chk($sformatf("e%0d_errs", nj), errs, 1);
        end
        // Asynchronous reset in mid-byte, then a clean packet.
        clr();
        sync_n(7); dbit(1); dbit(0); dbit(1); dbit(1); play(0);
        chk("r_active_before", rx_active, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("r_active", rx_active, 0);
        chk("r_data", rx_data, 8'h00);
        chk("r_valid", rx_valid, 0);
        chk("r_error", rx_error, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        idle(2);
        sync_n(7); put_byte(8'h5A); eop(); play(1);
        idle(4);
        chk("r_nbytes", got.size(), 1);
        chk("r_byte", got.size() > 0 ? 32'(got[0]) : 32'hDEAD, 8'h5A);
        chk("r_eops", eops, 1);
        chk("r_errs", errs, 0);
        // Long SE0 from idle.
        clr();
        sym(SE0, 0); sym(SE0, 0); sym(SE0, 0);
        chk("b_after3", bus_reset, 0);
        sym(SE0, 0);
`ifdef USB_RX_BUS_RESET_EN
        chk("b_after4", bus_reset, 1);
`else
        chk("b_after4", bus_reset, 0);
`endif
        sym(J, 0);
        chk("b_cleared", bus_reset, 0);
        idle(4);
        chk("b_eops", eops, 0);
        chk("b_errs", errs, 0);
        // Random packets against the encoder model.
        for (int p = 0; p < 25; p++) begin
            int nb;
            clr();
            exp_q.delete();
            nb = int'($urandom_range(1, 4));
            sync_n(int'($urandom_range(6, 7)));
            for (int i = 0; i < nb; i++) begin
                logic [7:0] b;
                b = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
                exp_q.push_back(b);
                put_byte(b);
            end
            eop();
            play(1);
            idle(4);
            chk($sformatf("p%0d_nbytes", p), got.size(), nb);
            for (int i = 0; i < nb; i++)
                chk($sformatf("p%0d_byte%0d", p, i), i < got.size() ? 32'(got[i]) : 32'hDEAD, exp_q[i]);
            chk($sformatf("p%0d_eops", p), eops, 1);
            chk($sformatf("p%0d_errs", p), errs, 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
